// File: rtl/ntt_pkg.sv
// Shared constants, FSM states and butterfly address helpers for the
// 256-point in-place NTT memory scheduler.
package ntt_pkg;

    localparam int unsigned N    = 256;
    localparam int unsigned LOGN = 8;
    localparam int unsigned HALF = 128;
    localparam int unsigned AW   = 8;
    localparam int unsigned SW   = 3;
    localparam int unsigned JW   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
    } bf_req_t;

    // Butterfly group index of butterfly j in stage s.
    function automatic logic [AW-1:0] bf_group(input logic [SW-1:0] s,
                                               input logic [JW-1:0] j);
        return AW'(j) >> (SW'(LOGN - 1) - s);
    endfunction

    // Operand pair addresses of butterfly j in stage s (valid always set).
    function automatic bf_req_t bf_addr(input logic [SW-1:0] s,
                                        input logic [JW-1:0] j);
        logic [AW-1:0] h;
        logic [AW-1:0] o;
        logic [AW-1:0] a;
        bf_req_t       r;
        h = AW'(HALF) >> s;
        o = AW'(j) & (h - AW'(1));
        a = (bf_group(s, j) << (4'(LOGN) - {1'b0, s})) | o;
        r.valid  = 1'b1;
        r.addr_a = a;
        r.addr_b = a + h;
        return r;
    endfunction

    // Twiddle ROM index of butterfly j in stage s.
    function automatic logic [AW-1:0] bf_twiddle(input logic [SW-1:0] s,
                                                 input logic [JW-1:0] j);
        return (AW'(1) << s) + bf_group(s, j);
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register carrying issued butterfly addresses to the
// write side once the butterfly pipeline result is available.
module ntt_delay_line
    import ntt_pkg::*;
#(
    parameter int unsigned DEPTH = 5
) (
    input  logic    clk,
    input  logic    rst_n,
    input  bf_req_t din,
    output bf_req_t dout
);

    bf_req_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_mem_sched.sv
// Ping-pong BRAM sequencer for an in-place 256-point radix-2 NTT: issues one
// butterfly read per cycle on one bank and retires results into the other.
module ntt_mem_sched
    import ntt_pkg::*;
#(
    parameter int unsigned BF_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] stage,
    output logic          rd_bank,
    output logic          bf_valid,
    output logic [AW-1:0] tw_addr,
    output logic          b0_we,
    output logic          b1_we,
    output logic [AW-1:0] b0_addr_a,
    output logic [AW-1:0] b0_addr_b,
    output logic [AW-1:0] b1_addr_a,
    output logic [AW-1:0] b1_addr_b
);

    // One cycle of BRAM read latency ahead of the butterfly pipeline.
    localparam int unsigned D = BF_LAT + 1;

    state_e        state_q, state_d;
    logic [JW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          issue_c;

    bf_req_t       iss_c;
    bf_req_t       dly_in_c;
    bf_req_t       wr_c;
    logic [AW-1:0] tw_c;
    logic          rd_issue_q;
    logic [AW-1:0] tw_q;
    logic [AW-1:0] b0_a_c, b0_b_c, b1_a_c, b1_b_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    // cnt is the butterfly index in RUN and the drain cycle count in DRAIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        issue_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                issue_c = 1'b1;
                if (cnt_q == JW'(HALF - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + JW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == JW'(D - 1)) begin
                    cnt_d = '0;
                    if (stage_q == SW'(LOGN - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + JW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        iss_c    = bf_addr(stage_q, cnt_q);
        tw_c     = bf_twiddle(stage_q, cnt_q);
        dly_in_c = issue_c ? iss_c : '0;
    end

    ntt_delay_line #(
        .DEPTH (D)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dly_in_c),
        .dout  (wr_c)
    );

    // Reads go to bank stage[0], writes to the other; idle ports park at 0.
    always_comb begin
        b0_a_c = '0;
        b0_b_c = '0;
        b1_a_c = '0;
        b1_b_c = '0;
        if (issue_c) begin
            if (stage_q[0]) begin
                b1_a_c = iss_c.addr_a;
                b1_b_c = iss_c.addr_b;
            end else begin
                b0_a_c = iss_c.addr_a;
                b0_b_c = iss_c.addr_b;
            end
        end
        if (wr_c.valid) begin
            if (stage_q[0]) begin
                b0_a_c = wr_c.addr_a;
                b0_b_c = wr_c.addr_b;
            end else begin
                b1_a_c = wr_c.addr_a;
                b1_b_c = wr_c.addr_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_issue_q <= 1'b0;
            tw_q       <= '0;
            bf_valid   <= 1'b0;
            tw_addr    <= '0;
            b0_we      <= 1'b0;
            b1_we      <= 1'b0;
            b0_addr_a  <= '0;
            b0_addr_b  <= '0;
            b1_addr_a  <= '0;
            b1_addr_b  <= '0;
        end else begin
            busy       <= (state_q == ST_RUN) || (state_q == ST_DRAIN);
            done       <= (state_q == ST_DONE);
            rd_issue_q <= issue_c;
            tw_q       <= issue_c ? tw_c : '0;
            bf_valid   <= rd_issue_q;
            tw_addr    <= tw_q;
            b0_we      <= wr_c.valid & stage_q[0];
            b1_we      <= wr_c.valid & ~stage_q[0];
            b0_addr_a  <= b0_a_c;
            b0_addr_b  <= b0_b_c;
            b1_addr_a  <= b1_a_c;
            b1_addr_b  <= b1_b_c;
        end
    end

    assign stage   = stage_q;
    assign rd_bank = stage_q[0];

endmodule
